jpeg_word_unpacker: RTL and testbench

- Receive end of the host-to-FPGA image stream feeding de1soc_top.
- Accepts 32-bit words: one header word holding the byte count, then ceil(count/4) payload words, bytes packed little-endian (byte k of the file in bits [8*(k%4)+7 : 8*(k%4)]).
- Emits a byte stream with a last-byte flag to the downstream JPEG parser. Discards padding bytes in the final word.

---
 rtl/jpeg_word_unpacker.sv | 167 ++++++++++++++++
 tb/tb_jpeg_word_unpacker.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_word_unpacker.sv
// jpeg_word_unpacker: turns a length-prefixed stream of 32-bit words into a
// byte stream with a last-byte flag for the JPEG parser.
// Word 0 of a frame carries the byte count in [LEN_W-1:0]. The following
// ceil(count/4) words carry the payload, packed little-endian. Padding bytes
// in the final word are discarded.
// Optional build macro UNPACK_MARKER_CHECK_EN enables the SOI/EOI marker
// checker, which drives a sticky marker_err. Without the macro, marker_err
// is tied low.
module jpeg_word_unpacker #(
    parameter int LEN_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        upstream_stall,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        downstream_stall,
    output logic        frame_done,
    output logic        marker_err
);

    localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] FOUR = LEN_W'(4);

    typedef enum logic [0:0] {
        ST_HDR,
        ST_PAY
    } state_t;

    state_t           state_reg;
    logic [31:0]      word_reg;
    logic             buf_valid_reg;
    logic [1:0]       idx_reg;
    logic [LEN_W-1:0] remaining_reg;   // bytes still to be emitted
    logic [LEN_W-1:0] unbuffered_reg;  // bytes not yet loaded into word_reg
    logic             frame_done_reg;

    logic [7:0]       lane [4];
    logic [LEN_W-1:0] hdr_len;
    logic             consume;
    logic             final_byte;
    logic             empties;
    logic             accept;

    // Split the buffered word into its four byte lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = word_reg[8*gi +: 8];
        end
    endgenerate

    assign hdr_len    = in_data[LEN_W-1:0];
    assign out_valid  = buf_valid_reg;
    assign out_data   = lane[idx_reg];
    assign out_last   = buf_valid_reg && (remaining_reg == ONE);
    assign frame_done = frame_done_reg;

    assign consume    = buf_valid_reg && !downstream_stall;
    assign final_byte = consume && (remaining_reg == ONE);
    assign empties    = consume && ((idx_reg == 2'd3) || (remaining_reg == ONE));
    assign accept     = in_valid && !upstream_stall;

    // Accept a word when idle in HDR, or in PAY when the buffer is free this
    // cycle and payload is still owed. Back-pressure on the final byte keeps
    // the next header from being swallowed by the ending frame.
    always_comb begin
        upstream_stall = 1'b0;
        if (state_reg == ST_PAY) begin
            upstream_stall = (buf_valid_reg && !empties) || final_byte ||
                             (unbuffered_reg == '0);
        end
    end

    // Frame sequencing, word buffering and byte indexing.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_reg      <= ST_HDR;
            buf_valid_reg  <= 1'b0;
            idx_reg        <= 2'd0;
            remaining_reg  <= '0;
            unbuffered_reg <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_HDR: begin
                    if (accept && (hdr_len != '0)) begin
                        remaining_reg  <= hdr_len;
                        unbuffered_reg <= hdr_len;
                        idx_reg        <= 2'd0;
                        buf_valid_reg  <= 1'b0;
                        state_reg      <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (final_byte) begin
                        state_reg      <= ST_HDR;
                        buf_valid_reg  <= 1'b0;
                        idx_reg        <= 2'd0;
                        remaining_reg  <= '0;
                        frame_done_reg <= 1'b1;
                    end else begin
                        if (consume) begin
                            remaining_reg <= remaining_reg - ONE;
                            idx_reg       <= idx_reg + 2'd1;
                        end
                        if (accept) begin
                            word_reg       <= in_data;
                            buf_valid_reg  <= 1'b1;
                            idx_reg        <= 2'd0;
                            unbuffered_reg <= (unbuffered_reg > FOUR) ?
                                              (unbuffered_reg - FOUR) : '0;
                        end else if (empties) begin
                            buf_valid_reg <= 1'b0;
                        end
                    end
                end
                default: state_reg <= ST_HDR;
            endcase
        end
    end

`ifdef UNPACK_MARKER_CHECK_EN
    localparam logic [LEN_W-1:0] TWO = LEN_W'(2);

    logic [LEN_W-1:0] len_reg;
    logic             marker_err_reg;
    logic [LEN_W-1:0] pos;
    logic             bad_byte;

    assign pos        = len_reg - remaining_reg;
    assign marker_err = marker_err_reg;

    // Compare the consumed byte against the SOI/EOI marker positions.
    always_comb begin
        bad_byte = 1'b0;
        if ((pos == '0) && (out_data != 8'hFF))
            bad_byte = 1'b1;
        if ((pos == ONE) && (out_data != 8'hD8))
            bad_byte = 1'b1;
        if ((remaining_reg == TWO) && (out_data != 8'hFF))
            bad_byte = 1'b1;
        if ((remaining_reg == ONE) && ((out_data != 8'hD9) || (len_reg < FOUR)))
            bad_byte = 1'b1;
    end

    // Latch the frame length and hold any marker violation until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_reg        <= '0;
            marker_err_reg <= 1'b0;
        end else begin
            if ((state_reg == ST_HDR) && accept)
                len_reg <= hdr_len;
            if (consume && bad_byte)
                marker_err_reg <= 1'b1;
        end
    end
`else
    assign marker_err = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_word_unpacker.sv
// Testbench for jpeg_word_unpacker: frames are built as byte arrays and
// packed into words. The expected byte stream (data + last flag) is queued
// per frame, and a per-cycle monitor checks every consumed byte against it.
module tb_jpeg_word_unpacker;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        upstream_stall;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        downstream_stall = 1'b0;
    logic        frame_done;
    logic        marker_err;

    jpeg_word_unpacker #(.LEN_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .flush(flush),
        .in_data(in_data),
        .in_valid(in_valid),
        .upstream_stall(upstream_stall),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_last(out_last),
        .downstream_stall(downstream_stall),
        .frame_done(frame_done),
        .marker_err(marker_err)
    );

    always #5 clock = ~clock;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [8:0]  exp_q [$];
    logic [7:0]  fb [0:511];
    logic [7:0]  log_b [0:2047];
    int          log_c [0:2047];
    int          log_n = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic        done_expect = 1'b0;
    logic        run_chk = 1'b0;
    int          stall_mode = 0;   // 0 off, 1 toggle, 2 random
    logic        gap_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Downstream back-pressure pattern.
    initial forever begin
        @(posedge clock);
        #1;
        case (stall_mode)
            1:       downstream_stall = ~downstream_stall;
            2:       downstream_stall = ($urandom_range(0, 99) < 30);
            default: downstream_stall = 1'b0;
        endcase
    end

    // Monitor: every consumed byte must match the head of the expected queue.
    initial forever begin
        logic next_done;
        logic [8:0] e;
        @(negedge clock);
        if (run_chk) begin
            next_done = 1'b0;
            chk("frame_done", {31'd0, frame_done}, {31'd0, done_expect});
            if (frame_done) done_cnt++;
            if (out_valid && !downstream_stall) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_byte", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                    chk("out_last", {31'd0, out_last}, {31'd0, e[8]});
                    if (e[8]) next_done = 1'b1;
                    if (log_n < 2048) begin
                        log_b[log_n] = out_data;
                        log_c[log_n] = cyc;
                        log_n++;
                    end
                end
            end
            if (out_valid && downstream_stall)
                chk("stall_while_holding", {31'd0, upstream_stall}, 32'd1);
            if (!out_valid)
                chk("out_last_idle", {31'd0, out_last}, 32'd0);
            done_expect = next_done;
        end
    end

    task automatic do_reset();
        run_chk  = 1'b0;
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        done_expect = 1'b0;
        run_chk = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        if (gap_mode && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            @(posedge clock);
            #1;
        end
        in_data  = w;
        in_valid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clock);
            acc = !upstream_stall;
            @(posedge clock);
            #1;
            n++;
        end
        chk("word_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_frame(input int len, input logic [15:0] upper);
        logic [31:0] w;
        int k;
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), fb[i]});
        send_word({upper, 16'(len)});
        for (int wi = 0; wi < (len + 3) / 4; wi++) begin
            w = $urandom;
            for (int b = 0; b < 4; b++) begin
                k = 4 * wi + b;
                if (k < len) w[8*b +: 8] = fb[k];
            end
            send_word(w);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("drained", exp_q.size(), 0);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
    endtask

    initial begin
        int n, d0, len;

        do_reset();
        @(negedge clock);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_upstream_stall", {31'd0, upstream_stall}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        @(posedge clock);
        #1;

        // 470-byte frame, no stalls: marker bytes at both ends, no bubbles.
        fill_random(470);
        fb[0] = 8'hFF; fb[1] = 8'hD8; fb[2] = 8'hFF; fb[3] = 8'hE0;
        fb[467] = 8'h15; fb[468] = 8'hFF; fb[469] = 8'hD9;
        log_n = 0;
        d0 = done_cnt;
        send_frame(470, 16'h0000);
        wait_drain();
        chk("f470_count", log_n, 470);
        chk("f470_b0", {24'd0, log_b[0]}, 32'hFF);
        chk("f470_b1", {24'd0, log_b[1]}, 32'hD8);
        chk("f470_b2", {24'd0, log_b[2]}, 32'hFF);
        chk("f470_b3", {24'd0, log_b[3]}, 32'hE0);
        chk("f470_b467", {24'd0, log_b[467]}, 32'h15);
        chk("f470_b468", {24'd0, log_b[468]}, 32'hFF);
        chk("f470_b469", {24'd0, log_b[469]}, 32'hD9);
        chk("f470_no_bubble", log_c[469] - log_c[0], 469);
        chk("f470_done", done_cnt - d0, 1);
        chk("f470_marker_err", {31'd0, marker_err}, 32'd0);

        // 8-byte frame with toggling back-pressure.
        stall_mode = 1;
        log_n = 0;
        for (int i = 0; i < 8; i++) fb[i] = 8'(i + 1);
        send_frame(8, 16'h0000);
        wait_drain();
        chk("f8_count", log_n, 8);
        for (int i = 0; i < 8; i++) chk("f8_byte", {24'd0, log_b[i]}, i + 1);
        stall_mode = 0;

        // Zero-length header, then a 5-byte frame of two words.
        log_n = 0;
        d0 = done_cnt;
        send_frame(0, 16'hA5A5);
        repeat (3) @(posedge clock);
        #1;
        chk("len0_silent", log_n, 0);
        fill_random(5);
        send_frame(5, 16'h0000);
        wait_drain();
        chk("f5_count", log_n, 5);
        chk("f5_done", done_cnt - d0, 1);

        // Flush after three bytes of a 12-byte frame.
        fill_random(12);
        log_n = 0;
        for (int i = 0; i < 12; i++) exp_q.push_back({(i == 11), fb[i]});
        send_word(32'd12);
        send_word({fb[3], fb[2], fb[1], fb[0]});
        in_valid = 1'b0;
        n = 0;
        while (log_n < 3 && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("flush_reach3", log_n, 3);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_upstream_stall", {31'd0, upstream_stall}, 32'd0);
        @(posedge clock);
        #1;
        log_n = 0;
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
        send_frame(4, 16'h0000);
        wait_drain();
        chk("post_flush_count", log_n, 4);
        chk("post_flush_b3", {24'd0, log_b[3]}, 32'h44);

        // Back-to-back 4-byte frames.
        log_n = 0;
        d0 = done_cnt;
        fill_random(4);
        send_frame(4, 16'h0000);
        fill_random(4);
        send_frame(4, 16'h0000);
        wait_drain();
        chk("b2b_count", log_n, 8);
        chk("b2b_done", done_cnt - d0, 2);
        chk("b2b_no_bubble_a", log_c[3] - log_c[0], 3);
        chk("b2b_no_bubble_b", log_c[7] - log_c[4], 3);

        // Randomized frames with random stalls and input gaps.
        stall_mode = 2;
        gap_mode = 1'b1;
        d0 = done_cnt;
        n = 0;
        for (int f = 0; f < 40; f++) begin
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 40);
            if (len != 0) n++;
            fill_random(len);
            send_frame(len, 16'($urandom));
        end
        wait_drain();
        chk("rand_done", done_cnt - d0, n);
        stall_mode = 0;
        gap_mode = 1'b0;

`ifdef UNPACK_MARKER_CHECK_EN
        do_reset();
        fb[0] = 8'hFE; fb[1] = 8'hD8; fb[2] = 8'hFF; fb[3] = 8'hD9;
        send_frame(4, 16'h0000);
        wait_drain();
        chk("marker_bad", {31'd0, marker_err}, 32'd1);
        fb[0] = 8'hFF;
        send_frame(4, 16'h0000);
        wait_drain();
        chk("marker_sticky", {31'd0, marker_err}, 32'd1);
        do_reset();
        chk("marker_reset", {31'd0, marker_err}, 32'd0);
        send_frame(4, 16'h0000);
        wait_drain();
        chk("marker_good", {31'd0, marker_err}, 32'd0);
`else
        chk("marker_tied", {31'd0, marker_err}, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
